// File: rtl/fetch_unit.sv
// PC + fetch stage: drives pc to instruction memory and registers the returned word toward decode.
// One cycle pc->ir_out; stalls hold everything while ir_valid && !ir_ready; branch flushes the IR.
module fetch_unit #(
  parameter int unsigned     PC_W        = 8,
  parameter int unsigned     INSTR_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] current_instruction,
  output logic [INSTR_W-1:0] ir_out,
  output logic [PC_W-1:0]    ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               resume,
  output logic               halted
);

  typedef enum logic {S_FETCH = 1'b0, S_HALT = 1'b1} state_t;

  state_t              r_state, w_state_nxt;
  logic [PC_W-1:0]     r_pc, w_pc_nxt;
  logic [INSTR_W-1:0]  r_ir, w_ir_nxt;
  logic [PC_W-1:0]     r_ir_pc, w_ir_pc_nxt;
  logic                r_ir_vld, w_ir_vld_nxt;
  logic                w_slot_free;
  logic                w_is_halt;
  logic [PC_W-1:0]     w_pc_inc;

  assign w_slot_free = !r_ir_vld || ir_ready;
  assign w_is_halt   = (current_instruction[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign w_pc_inc    = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_ir_pc  <= '0;
      r_ir_vld <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_ir_pc  <= w_ir_pc_nxt;
      r_ir_vld <= w_ir_vld_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_ir_pc_nxt  = r_ir_pc;
    w_ir_vld_nxt = r_ir_vld;
    // A redirect overrides everything, including a resume and a same-cycle accept.
    if (branch_taken) begin
      w_pc_nxt     = branch_target;
      w_ir_vld_nxt = 1'b0;
      w_state_nxt  = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_slot_free) begin
            w_ir_nxt     = current_instruction;
            w_ir_pc_nxt  = r_pc;
            w_ir_vld_nxt = 1'b1;
            if (w_is_halt) w_state_nxt = S_HALT;
            else           w_pc_nxt    = w_pc_inc;
          end
        end
        S_HALT: begin
          if (r_ir_vld && ir_ready) w_ir_vld_nxt = 1'b0;
          if (resume) begin
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end
        end
        default: w_state_nxt = S_FETCH;
      endcase
    end
  end

  assign pc       = r_pc;
  assign ir_out   = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_vld;
  assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory array, cycle-level reference model and directed scenarios.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  pc;
  logic [15:0] current_instruction;
  logic [15:0] ir_out;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        resume;
  logic        halted;

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign current_instruction = mem[pc];

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .current_instruction(current_instruction),
    .ir_out(ir_out), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .branch_taken(branch_taken), .branch_target(branch_target), .resume(resume),
    .halted(halted)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the architectural state the outputs must reflect.
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_ir_pc;
  logic        m_vld;
  logic        m_halt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc <= 8'd0; m_ir <= 16'd0; m_ir_pc <= 8'd0; m_vld <= 1'b0; m_halt <= 1'b0;
    end else if (branch_taken) begin
      m_pc <= branch_target; m_vld <= 1'b0; m_halt <= 1'b0;
    end else if (!m_halt) begin
      if (!m_vld || ir_ready) begin
        m_ir <= mem[m_pc]; m_ir_pc <= m_pc; m_vld <= 1'b1;
        if (mem[m_pc][15:12] == 4'hF) m_halt <= 1'b1;
        else                          m_pc   <= m_pc + 8'd1;
      end
    end else begin
      if (m_vld && ir_ready) m_vld <= 1'b0;
      if (resume) begin
        m_pc <= m_pc + 8'd1; m_halt <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_pc", {24'd0, pc}, {24'd0, m_pc});
    chk("cmp_vld", {31'd0, ir_valid}, {31'd0, m_vld});
    chk("cmp_halted", {31'd0, halted}, {31'd0, m_halt});
    chk("cmp_ir", {16'd0, ir_out}, {16'd0, m_ir});
    chk("cmp_irpc", {24'd0, ir_pc}, {24'd0, m_ir_pc});
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input logic [15:0] e_ir, input logic [7:0] e_irpc,
                     input logic e_vld, input logic [7:0] e_pc, input logic e_halt);
    chk({nm, "_ir"}, {16'd0, ir_out}, {16'd0, e_ir});
    chk({nm, "_irpc"}, {24'd0, ir_pc}, {24'd0, e_irpc});
    chk({nm, "_vld"}, {31'd0, ir_valid}, {31'd0, e_vld});
    chk({nm, "_pc"}, {24'd0, pc}, {24'd0, e_pc});
    chk({nm, "_halt"}, {31'd0, halted}, {31'd0, e_halt});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 | 16'(i);
    mem[0] = 16'h1234; mem[1] = 16'h2345; mem[2] = 16'h3456;
    mem[4] = 16'hF000; mem[10] = 16'hABCD;
    mem[8'hFE] = 16'h7EFE; mem[8'hFF] = 16'h7FFF;

    rst_n = 1'b0; ir_ready = 1'b1; branch_taken = 1'b0; branch_target = 8'd0; resume = 1'b0;
    #3;
    lit("reset", 16'h0000, 8'd0, 1'b0, 8'd0, 1'b0);
    #9 rst_n = 1'b1;

    // Back-to-back fetch at full throughput
    cyc(); lit("t1_a", 16'h1234, 8'd0, 1'b1, 8'd1, 1'b0);
    cyc(); lit("t1_b", 16'h2345, 8'd1, 1'b1, 8'd2, 1'b0);
    cyc(); lit("t1_c", 16'h3456, 8'd2, 1'b1, 8'd3, 1'b0);

    // Stall after first capture
    rst_n = 1'b0; #4 rst_n = 1'b1;
    cyc(); lit("t2_cap", 16'h1234, 8'd0, 1'b1, 8'd1, 1'b0);
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(); lit("t2_stall", 16'h1234, 8'd0, 1'b1, 8'd1, 1'b0);
    end
    ir_ready = 1'b1;
    cyc(); lit("t2_go", 16'h2345, 8'd1, 1'b1, 8'd2, 1'b0);

    // Branch with flush while decode is accepting
    branch_taken = 1'b1; branch_target = 8'd10;
    cyc(); lit("t3_flush", 16'h2345, 8'd1, 1'b0, 8'd10, 1'b0);
    branch_taken = 1'b0;
    cyc(); lit("t3_tgt", 16'hABCD, 8'd10, 1'b1, 8'd11, 1'b0);

    // Halt, accept, resume
    branch_taken = 1'b1; branch_target = 8'd4;
    cyc(); branch_taken = 1'b0;
    cyc(); lit("t4_halt", 16'hF000, 8'd4, 1'b1, 8'd4, 1'b1);
    cyc(); lit("t4_acc", 16'hF000, 8'd4, 1'b0, 8'd4, 1'b1);
    cyc(); lit("t4_hold", 16'hF000, 8'd4, 1'b0, 8'd4, 1'b1);
    resume = 1'b1;
    cyc(); lit("t4_res", 16'hF000, 8'd4, 1'b0, 8'd5, 1'b0);
    resume = 1'b0;
    cyc(); lit("t4_next", 16'h0105, 8'd5, 1'b1, 8'd6, 1'b0);

    // Halt with stalled decode, then branch and resume together: branch wins
    branch_taken = 1'b1; branch_target = 8'd4;
    cyc(); branch_taken = 1'b0;
    ir_ready = 1'b0;
    cyc(); lit("t4b_halt", 16'hF000, 8'd4, 1'b1, 8'd4, 1'b1);
    cyc(); lit("t4b_held", 16'hF000, 8'd4, 1'b1, 8'd4, 1'b1);
    ir_ready = 1'b1; resume = 1'b1; branch_taken = 1'b1; branch_target = 8'd20;
    cyc(); lit("t4b_br", 16'hF000, 8'd4, 1'b0, 8'd20, 1'b0);
    resume = 1'b0; branch_taken = 1'b0;
    cyc(); lit("t4b_tgt", 16'h0114, 8'd20, 1'b1, 8'd21, 1'b0);

    // PC wrap
    branch_taken = 1'b1; branch_target = 8'hFE;
    cyc(); branch_taken = 1'b0;
    cyc(); lit("t5_fe", 16'h7EFE, 8'hFE, 1'b1, 8'hFF, 1'b0);
    cyc(); lit("t5_ff", 16'h7FFF, 8'hFF, 1'b1, 8'h00, 1'b0);
    cyc(); lit("t5_wrap", 16'h1234, 8'h00, 1'b1, 8'h01, 1'b0);

    // Asynchronous reset mid-stream
    branch_taken = 1'b1; branch_target = 8'd6;
    cyc(); branch_taken = 1'b0;
    cyc(); lit("t6_pre", 16'h0106, 8'd6, 1'b1, 8'd7, 1'b0);
    #1 rst_n = 1'b0;
    #1 lit("t6_async", 16'h0000, 8'd0, 1'b0, 8'd0, 1'b0);
    #3 rst_n = 1'b1;
    cyc(); lit("t6_restart", 16'h1234, 8'd0, 1'b1, 8'd1, 1'b0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
